// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard / forwarding controller.
package hazard_pkg;

  // Forward-mux select encoding, shared with the datapath operand muxes
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EXM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_MDU = 2'b11
  } fwd_sel_e;

  // Data-memory handshake tracking
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  // Architectural x0: never a hazard, never forwarded
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/mdu_scoreboard.sv
// Tracks the single in-flight multi-cycle MDU op: pending-register bitmap,
// latency countdown, latched destination and the one-cycle completion pulse.
// All state holds while the pipeline is frozen.
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int MDU_LAT  = 4,
  parameter int CNT_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                freeze,
  input  logic                issue_req,
  input  logic [REG_AW-1:0]   issue_rd,
  output logic [NUM_REGS-1:0] pending,
  output logic                busy,
  output logic                done,
  output logic [REG_AW-1:0]   done_rd
);

  logic [CNT_W-1:0]    cnt_q;
  logic [REG_AW-1:0]   rd_q;
  logic                busy_q;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                issue;

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == '0) && !freeze;
  assign done_rd = rd_q;
  assign pending = pending_q;

  // A new op may start when idle or in the very cycle the old one retires
  assign issue = issue_req && !freeze && (!busy_q || done);

  // Next bitmap: release the retiring register first, then claim the new one
  always_comb begin
    pending_d = pending_q;
    if (done) begin
      pending_d[rd_q] = 1'b0;
    end
    if (issue && (issue_rd != REG_AW'(REG_ZERO))) begin
      pending_d[issue_rd] = 1'b1;
    end
  end

  // Counter, latched rd and bitmap advance only on unfrozen cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      rd_q      <= '0;
      busy_q    <= 1'b0;
      pending_q <= '0;
    end else if (!freeze) begin
      if (issue) begin
        busy_q <= 1'b1;
        cnt_q  <= CNT_W'(MDU_LAT - 1);
        rd_q   <= issue_rd;
      end else if (done) begin
        busy_q <= 1'b0;
      end else if (busy_q) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall / flush / freeze / forwarding control for the 5-stage RV32
// pipeline, including the variable-latency data-memory freeze and the MDU
// scoreboard with completion bypass.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_REGS = 32,
  parameter int MDU_LAT  = 4,
  parameter int CNT_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_regwrite,
  input  logic                id_is_mdu,
  input  logic [REG_AW-1:0]   ex_rs1,
  input  logic [REG_AW-1:0]   ex_rs2,
  input  logic [REG_AW-1:0]   ex_rd,
  input  logic                ex_regwrite,
  input  logic                ex_memread,
  input  logic                ex_is_mdu,
  input  logic [REG_AW-1:0]   mem_rd,
  input  logic                mem_regwrite,
  input  logic                mem_memread,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic                wb_regwrite,
  input  logic                br_redirect,
  input  logic                dmem_req,
  input  logic                dmem_ready,
  output logic                stall_fe,
  output logic                bubble_ex,
  output logic                flush_fe,
  output logic                freeze,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                mdu_done,
  output logic [REG_AW-1:0]   mdu_done_rd,
  output logic [NUM_REGS-1:0] sb_pending
);

  hz_state_e           state_q;
  hz_state_e           state_d;
  logic                freeze_c;
  logic [NUM_REGS-1:0] pending;
  logic                mdu_busy;
  logic                done;
  logic [REG_AW-1:0]   done_rd;
  logic                hazard;
  logic                unused_ex_regwrite;

  // EX write-enable is not needed: load-use and MDU issue key off their own flags
  assign unused_ex_regwrite = ex_regwrite;

  mdu_scoreboard #(
    .REG_AW  (REG_AW),
    .NUM_REGS(NUM_REGS),
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .freeze   (freeze_c),
    .issue_req(ex_is_mdu && !br_redirect),
    .issue_rd (ex_rd),
    .pending  (pending),
    .busy     (mdu_busy),
    .done     (done),
    .done_rd  (done_rd)
  );

  // Forward select for one EX operand; x0 is never forwarded
  function automatic fwd_sel_e pick_fwd(
    input logic [REG_AW-1:0] rs,
    input logic              done_v,
    input logic [REG_AW-1:0] done_rd_v,
    input logic              mem_we,
    input logic              mem_ld,
    input logic [REG_AW-1:0] mem_rd_v,
    input logic              wb_we,
    input logic [REG_AW-1:0] wb_rd_v
  );
    if (rs == REG_AW'(REG_ZERO))            return FWD_RF;
    if (done_v && (done_rd_v == rs))        return FWD_MDU;
    if (mem_we && !mem_ld && (mem_rd_v == rs)) return FWD_EXM;
    if (wb_we && (wb_rd_v == rs))           return FWD_WB;
    return FWD_RF;
  endfunction

  // Memory-wait FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory-wait next state; freeze follows the live handshake in both states
  always_comb begin
    state_d  = state_q;
    freeze_c = 1'b0;
    case (state_q)
      RUN: begin
        freeze_c = dmem_req && !dmem_ready;
        if (freeze_c) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        freeze_c = dmem_req && !dmem_ready;
        if (dmem_ready) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Collect every reason the ID instruction cannot advance this cycle
  always_comb begin
    hazard = 1'b0;
    if (ex_memread && (ex_rd != REG_AW'(REG_ZERO)) &&
        ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)))) begin
      hazard = 1'b1;
    end
    if (id_use_rs1 && pending[id_rs1] && !(done && (done_rd == id_rs1))) begin
      hazard = 1'b1;
    end
    if (id_use_rs2 && pending[id_rs2] && !(done && (done_rd == id_rs2))) begin
      hazard = 1'b1;
    end
    if (id_regwrite && pending[id_rd] && !(done && (done_rd == id_rd))) begin
      hazard = 1'b1;
    end
    if (id_is_mdu && mdu_busy && !done) begin
      hazard = 1'b1;
    end
  end

  // Resolve freeze over flush over stall into pipeline-register controls
  always_comb begin
    stall_fe  = 1'b0;
    bubble_ex = 1'b0;
    flush_fe  = 1'b0;
    if (!freeze_c) begin
      if (br_redirect) begin
        flush_fe  = 1'b1;
        bubble_ex = 1'b1;
      end else if (hazard) begin
        stall_fe  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  assign freeze      = freeze_c;
  assign fwd_a       = pick_fwd(ex_rs1, done, done_rd, mem_regwrite, mem_memread,
                                mem_rd, wb_regwrite, wb_rd);
  assign fwd_b       = pick_fwd(ex_rs2, done, done_rd, mem_regwrite, mem_memread,
                                mem_rd, wb_regwrite, wb_rd);
  assign mdu_done    = done;
  assign mdu_done_rd = done_rd;
  assign sb_pending  = pending;

endmodule
